// File: rtl/fpga_cfg_loader_if.sv
// Config-word handshake between a word source and the fabric configuration loader.
interface fpga_cfg_loader_if #(
  parameter int NUM_CHAINS = 1
);
  logic [NUM_CHAINS-1:0] din;
  logic                  din_valid;
  logic                  din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/fpga_cfg_loader.sv
// Shifts config words into NUM_CHAINS fabric chains with a generated prog_clk, optionally
// recirculates each chain once to CRC-check the tail readback, then releases fabric reset.
module fpga_cfg_loader #(
  parameter int CHAIN_LEN  = 256,
  parameter int NUM_CHAINS = 1,
  parameter int DIV        = 1,
  parameter int VERIFY_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  fpga_cfg_loader_if.slave      cfg,
  output logic                  prog_clk,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  fabric_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LEN_C    = CW'(CHAIN_LEN);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] LO    = 3'd2;
  localparam logic [2:0] HI    = 3'd3;
  localparam logic [2:0] VLO   = 3'd4;
  localparam logic [2:0] VHI   = 3'd5;
  localparam logic [2:0] CHECK = 3'd6;

  logic [2:0]            state_reg;
  logic [DW-1:0]         div_cnt_reg;
  logic [CW-1:0]         cnt_reg;
  logic [15:0]           crc_load_reg;
  logic [15:0]           crc_rb_reg;
  logic                  prog_clk_reg;
  logic                  din_ready_reg;
  logic                  fabric_rst_n_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [NUM_CHAINS-1:0] head_reg;
  logic [NUM_CHAINS-1:0] head_next;

  logic accept;
  logic phase_end;
  logic capture;

  // CRC-16-CCITT, MSB-first, lane 0 shifted in first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [NUM_CHAINS-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign accept    = ena && (state_reg == WAIT) && din_ready_reg && cfg.din_valid;
  assign phase_end = (div_cnt_reg == DIV_LAST);
  // Tail is captured at the end of each high phase whose shifted-out bit still belongs to the readback.
  assign capture   = ena && phase_end &&
                     (((state_reg == HI) && (cnt_reg >= LEN_C) && (VERIFY_EN != 0)) ||
                      ((state_reg == VHI) && (cnt_reg < LEN_C)));

  for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_lane
    assign head_next[gi] = accept  ? cfg.din[gi] :
                           capture ? ccff_tail[gi] : head_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      div_cnt_reg      <= '0;
      cnt_reg          <= '0;
      crc_load_reg     <= 16'hFFFF;
      crc_rb_reg       <= 16'hFFFF;
      prog_clk_reg     <= 1'b0;
      din_ready_reg    <= 1'b0;
      fabric_rst_n_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
      head_reg         <= '0;
    end else begin
      done_reg <= 1'b0;
      head_reg <= head_next;
      if (ena) begin
        if (capture) crc_rb_reg <= crc_step(crc_rb_reg, ccff_tail);
        case (state_reg)
          IDLE: if (start) begin
            state_reg        <= WAIT;
            err_reg          <= 1'b0;
            crc_load_reg     <= 16'hFFFF;
            crc_rb_reg       <= 16'hFFFF;
            cnt_reg          <= '0;
            fabric_rst_n_reg <= 1'b0;
            busy_reg         <= 1'b1;
            din_ready_reg    <= 1'b1;
          end
          WAIT: if (accept) begin
            din_ready_reg <= 1'b0;
            crc_load_reg  <= crc_step(crc_load_reg, cfg.din);
            div_cnt_reg   <= '0;
            state_reg     <= LO;
          end
          LO, VLO: if (phase_end) begin
            div_cnt_reg  <= '0;
            prog_clk_reg <= 1'b1;
            cnt_reg      <= cnt_reg + 1'b1;
            state_reg    <= (state_reg == LO) ? HI : VHI;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
          HI: if (phase_end) begin
            div_cnt_reg  <= '0;
            prog_clk_reg <= 1'b0;
            if (cnt_reg < LEN_C) begin
              state_reg     <= WAIT;
              din_ready_reg <= 1'b1;
            end else if (VERIFY_EN != 0) begin
              state_reg <= VLO;
              cnt_reg   <= '0;
            end else begin
              state_reg <= CHECK;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
          VHI: if (phase_end) begin
            div_cnt_reg  <= '0;
            prog_clk_reg <= 1'b0;
            state_reg    <= (cnt_reg < LEN_C) ? VLO : CHECK;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
          CHECK: begin
            if ((VERIFY_EN != 0) && (crc_load_reg != crc_rb_reg)) err_reg <= 1'b1;
            else fabric_rst_n_reg <= 1'b1;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign cfg.din_ready = din_ready_reg & ena;
  assign prog_clk      = prog_clk_reg;
  assign ccff_head     = head_reg;
  assign fabric_rst_n  = fabric_rst_n_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign err           = err_reg;
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Drives three loader configurations against behavioural shift-chain fabrics and checks
// chain contents, edge counts, prog_clk phases, handshake gaps, freeze, reset and CRC error paths.
module tb_fpga_cfg_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] dv = '0;
  logic [3:0] din_bus = '0;
  logic       stuck_b = 1'b0;

  wire [2:0] pc, rdy, busy_v, done_v, err_v, frst;
  wire       head_a, head_b;
  wire [3:0] head_c;
  wire [3:0] head_v [3];

  logic [15:0] chain_m [3][4];
  int          edges [3];
  logic [2:0]  pc_prev = '0;
  int          gap_bad = 0;
  int          hi_run = 0, hi_runs = 0, hi_bad = 0, lo_run = 0, lo_bad = 0;
  logic [3:0]  wq [$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign head_v[0] = {3'b000, head_a};
  assign head_v[1] = {3'b000, head_b};
  assign head_v[2] = head_c;

  wire       tail_a = chain_m[0][0][7];
  wire       tail_b = chain_m[1][0][7];
  wire [3:0] tail_c = {chain_m[2][3][15], chain_m[2][2][15], chain_m[2][1][15], chain_m[2][0][15]};

  fpga_cfg_loader_if #(.NUM_CHAINS(1)) if_a ();
  fpga_cfg_loader_if #(.NUM_CHAINS(1)) if_b ();
  fpga_cfg_loader_if #(.NUM_CHAINS(4)) if_c ();
  assign if_a.din = din_bus[0:0];
  assign if_b.din = din_bus[0:0];
  assign if_c.din = din_bus;
  assign if_a.din_valid = dv[0];
  assign if_b.din_valid = dv[1];
  assign if_c.din_valid = dv[2];
  assign rdy[0] = if_a.din_ready;
  assign rdy[1] = if_b.din_ready;
  assign rdy[2] = if_c.din_ready;

  fpga_cfg_loader #(.CHAIN_LEN(8), .NUM_CHAINS(1), .DIV(1), .VERIFY_EN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_v[0]), .cfg(if_a),
    .prog_clk(pc[0]), .ccff_head(head_a), .ccff_tail(tail_a), .fabric_rst_n(frst[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]));

  fpga_cfg_loader #(.CHAIN_LEN(8), .NUM_CHAINS(1), .DIV(2), .VERIFY_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_v[1]), .cfg(if_b),
    .prog_clk(pc[1]), .ccff_head(head_b), .ccff_tail(tail_b), .fabric_rst_n(frst[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]));

  fpga_cfg_loader #(.CHAIN_LEN(16), .NUM_CHAINS(4), .DIV(3), .VERIFY_EN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_v[2]), .cfg(if_c),
    .prog_clk(pc[2]), .ccff_head(head_c), .ccff_tail(tail_c), .fabric_rst_n(frst[2]),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]));

  // Fabric model: each chain shifts head in at every prog_clk rise (seen at the following negedge,
  // while prog_clk is still high and head is stable); chain b can carry a stuck-at-0 flop at bit 3.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pc[k] && !pc_prev[k]) begin
        edges[k] <= edges[k] + 1;
        for (int l = 0; l < 4; l++)
          chain_m[k][l] <= {chain_m[k][l][14:0], head_v[k][l]} &
                           ((k == 1 && stuck_b) ? 16'hFFF7 : 16'hFFFF);
      end
      if (rdy[k] && pc[k]) gap_bad <= gap_bad + 1;
    end
    if (pc[2]) begin
      hi_run <= hi_run + 1;
      lo_run <= 0;
      if (!pc_prev[2] && lo_run < 3) lo_bad <= lo_bad + 1;
    end else begin
      lo_run <= lo_run + 1;
      if (hi_run != 0) begin
        hi_runs <= hi_runs + 1;
        if (hi_run != 3) hi_bad <= hi_bad + 1;
        hi_run <= 0;
      end
    end
    pc_prev <= pc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
  endtask

  // Expected chain image: word j of the load ends at position LEN-1-j (first word at the tail).
  function automatic logic [15:0] exp_lane(input int len, input int lane);
    logic [15:0] v;
    v = '0;
    for (int j = 0; j < len; j++) v[len-1-j] = wq[j][lane];
    return v;
  endfunction

  task automatic gen_words(input int n, input int nbits);
    wq.delete();
    for (int j = 0; j < n; j++) wq.push_back(4'($urandom_range(0, (1 << nbits) - 1)));
  endtask

  task automatic check_reset(input int k, input string tag);
    chk({tag, "_prog_clk"}, pc[k], 0);
    chk({tag, "_din_ready"}, rdy[k], 0);
    chk({tag, "_busy"}, busy_v[k], 0);
    chk({tag, "_done"}, done_v[k], 0);
    chk({tag, "_err"}, err_v[k], 0);
    chk({tag, "_fabric_rst_n"}, frst[k], 0);
    chk({tag, "_ccff_head"}, head_v[k], 0);
  endtask

  task automatic do_start(input int k, input string tag);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    chk({tag, "_busy_after_start"}, busy_v[k], 1);
    chk({tag, "_err_cleared"}, err_v[k], 0);
    chk({tag, "_fabric_rst_low"}, frst[k], 0);
  endtask

  // gap=1 offers a word only every third cycle; pause_at>=0 freezes with ena=0 while start is held.
  task automatic run_load(input int k, input int n, input int gap, input int pause_at);
    int idx = 0;
    int cyc = 0;
    int start_hold = 0;
    bit paused = 1'b0;
    bit hit;
    int frz_bad;
    int e0;
    while (idx < n && cyc < 4000) begin
      if (idx == pause_at && !paused) begin
        paused = 1'b1;
        dv[k] = 1'b0;
        @(negedge clk);
        chk("t6_prog_clk_high_at_pause", pc[k], 1);
        ena = 1'b0;
        start_v[k] = 1'b1;
        #1 e0 = edges[k];
        frz_bad = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (pc[k] !== 1'b1 || rdy[k] !== 1'b0 || busy_v[k] !== 1'b1) frz_bad++;
        end
        chk("t6_frozen_cycles_bad", frz_bad, 0);
        chk("t6_edges_while_frozen", edges[k] - e0, 0);
        ena = 1'b1;
        start_hold = 4;
      end
      din_bus = wq[idx];
      dv[k] = (gap == 0) || (cyc % 3 == 0);
      hit = dv[k] && rdy[k];
      @(negedge clk);
      cyc++;
      if (start_hold > 0) begin
        start_hold--;
        if (start_hold == 0) start_v[k] = 1'b0;
      end
      if (hit) idx++;
    end
    dv[k] = 1'b0;
    start_v[k] = 1'b0;
    chk("words_accepted", idx, n);
  endtask

  task automatic wait_done(input int k, input int bound, input string tag);
    int c = 0;
    while (done_v[k] !== 1'b1 && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done_seen"}, done_v[k], 1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done_v[k], 0);
    chk({tag, "_busy_idle"}, busy_v[k], 0);
  endtask

  initial begin
    int e0, gb0, hr0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset(k, "por");
    rst_n = 1'b1;
    @(negedge clk);

    // T1: fixed words, no verify
    wq = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
    e0 = edges[0];
    do_start(0, "t1");
    run_load(0, 8, 0, -1);
    wait_done(0, 400, "t1");
    chk("t1_edges", edges[0] - e0, 8);
    chk("t1_chain", chain_m[0][0][7:0], 8'b10110010);
    chk("t1_fabric_rst_n", frst[0], 1);
    chk("t1_err", err_v[0], 0);

    // T2: verify pass on an ideal chain
    gen_words(8, 1);
    e0 = edges[1];
    do_start(1, "t2");
    run_load(1, 8, 0, -1);
    wait_done(1, 800, "t2");
    chk("t2_edges", edges[1] - e0, 16);
    chk("t2_chain_restored", chain_m[1][0] & 16'h00FF, exp_lane(8, 0));
    chk("t2_err", err_v[1], 0);
    chk("t2_fabric_rst_n", frst[1], 1);

    // T3: stuck-at-0 flop zeroes every word passing it, so readback differs from nonzero data
    gen_words(8, 1);
    wq[0] = 4'd1;
    stuck_b = 1'b1;
    do_start(1, "t3");
    run_load(1, 8, 0, -1);
    wait_done(1, 800, "t3");
    chk("t3_err", err_v[1], 1);
    chk("t3_fabric_rst_n_held", frst[1], 0);
    stuck_b = 1'b0;

    // T3b: a clean reload clears the sticky error
    gen_words(8, 1);
    do_start(1, "t3b");
    run_load(1, 8, 0, -1);
    wait_done(1, 800, "t3b");
    chk("t3b_err", err_v[1], 0);
    chk("t3b_fabric_rst_n", frst[1], 1);
    chk("t3b_chain", chain_m[1][0] & 16'h00FF, exp_lane(8, 0));

    // T4: sparse din_valid
    gen_words(8, 1);
    e0 = edges[0];
    gb0 = gap_bad;
    do_start(0, "t4");
    run_load(0, 8, 1, -1);
    wait_done(0, 800, "t4");
    chk("t4_edges", edges[0] - e0, 8);
    chk("t4_chain", chain_m[0][0] & 16'h00FF, exp_lane(8, 0));
    chk("t4_prog_clk_high_while_ready", gap_bad - gb0, 0);

    // T5: four lanes, DIV=3, reset mid-load then full reload
    gen_words(16, 4);
    do_start(2, "t5a");
    run_load(2, 5, 0, -1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_reset(k, "t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gen_words(16, 4);
    e0 = edges[2];
    hr0 = hi_runs;
    do_start(2, "t5");
    run_load(2, 16, 0, -1);
    wait_done(2, 3000, "t5");
    chk("t5_edges", edges[2] - e0, 32);
    for (int l = 0; l < 4; l++) chk($sformatf("t5_chain_lane%0d", l), chain_m[2][l], exp_lane(16, l));
    chk("t5_err", err_v[2], 0);
    chk("t5_fabric_rst_n", frst[2], 1);
    chk("t5_high_phases", hi_runs - hr0, 32);
    chk("t5_high_phase_not_3", hi_bad, 0);
    chk("t5_low_phase_short", lo_bad, 0);

    // T6: start re-asserted while busy plus a 10-cycle ena freeze mid-load
    gen_words(8, 1);
    e0 = edges[0];
    do_start(0, "t6");
    run_load(0, 8, 0, 3);
    wait_done(0, 800, "t6");
    chk("t6_edges", edges[0] - e0, 8);
    chk("t6_chain", chain_m[0][0] & 16'h00FF, exp_lane(8, 0));
    chk("t6_fabric_rst_n", frst[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
